// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shared-memory arbiter sequencing I/D cache block fills and D writes onto memory4c
// Optional: define ARB_ROUND_ROBIN_EN to alternate grants under contention instead of fixed D-over-I.
module mem_arbiter #(
  parameter int MEM_LAT   = 4,
  parameter int BLK_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        i_fill_valid,
  output logic        d_fill_valid,
  output logic [15:0] fill_data,
  output logic [2:0]  fill_idx,
  output logic        i_done,
  output logic        d_done,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  input  logic [15:0] mem_data_out,
  input  logic        mem_data_valid
);

  localparam int W = $clog2(BLK_WORDS);

  if (MEM_LAT < 1 || BLK_WORDS < 2 || (BLK_WORDS & (BLK_WORDS - 1)) != 0) begin : g_bad_cfg
    $error("mem_arbiter: MEM_LAT must be >= 1 and BLK_WORDS a power of two >= 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_I_FILL, S_D_FILL, S_D_WRITE, S_DONE} state_t;

  state_t       r_state;
  state_t       w_next;
  logic [15:0]  r_addr;
  logic [W:0]   r_iss;
  logic [W-1:0] r_ret;
  logic         w_pick_d;
  logic         w_fill;
  logic         w_last_ret;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_d;

  // Under contention, the side that did not win the previous grant goes next.
  assign w_pick_d = d_req & (~i_req | ~r_last_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_d <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (w_pick_d) r_last_d <= 1'b1;
      else if (i_req) r_last_d <= 1'b0;
    end
  end
`else
  assign w_pick_d = d_req;
`endif

  assign w_fill     = (r_state == S_I_FILL) || (r_state == S_D_FILL);
  assign w_last_ret = mem_data_valid & (&r_ret);
  assign fill_data  = mem_data_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_iss   <= '0;
      r_ret   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE) begin
        r_iss <= '0;
        r_ret <= '0;
        if (w_pick_d) r_addr <= d_addr;
        else if (i_req) r_addr <= i_addr;
      end else if (w_fill) begin
        // r_iss[W] set means every word of the block has been issued.
        if (!r_iss[W]) r_iss <= r_iss + 1'b1;
        if (mem_data_valid) r_ret <= r_ret + 1'b1;
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    i_fill_valid = 1'b0;
    d_fill_valid = 1'b0;
    fill_idx     = '0;
    i_done       = 1'b0;
    d_done       = 1'b0;
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_data_in  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_pick_d) w_next = d_wr ? S_D_WRITE : S_D_FILL;
        else if (i_req) w_next = S_I_FILL;
      end
      S_I_FILL, S_D_FILL: begin
        if (!r_iss[W]) begin
          mem_en   = 1'b1;
          mem_addr = {r_addr[15:W+1], r_iss[W-1:0], 1'b0};
        end
        fill_idx = 3'(r_ret);
        if (r_state == S_D_FILL) begin
          d_fill_valid = mem_data_valid;
          d_done       = w_last_ret;
        end else begin
          i_fill_valid = mem_data_valid;
          i_done       = w_last_ret;
        end
        if (w_last_ret) w_next = S_DONE;
      end
      S_D_WRITE: begin
        mem_en      = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = r_addr;
        mem_data_in = d_wdata;
        d_done      = 1'b1;
        w_next      = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a pipelined memory model
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int MEM_LAT = 4;
  localparam int BLK     = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic        i_fill_valid, d_fill_valid, i_done, d_done, mem_en, mem_wr;
  logic [15:0] fill_data, mem_addr, mem_data_in, mem_data_out;
  logic [2:0]  fill_idx;
  logic        mem_data_valid;

  typedef struct {logic own_d; logic [2:0] idx; logic [15:0] data;} sb_t;
  sb_t sb[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  logic [MEM_LAT-1:0] p_v = '0;
  logic [15:0]        p_a [MEM_LAT];

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(MEM_LAT), .BLK_WORDS(BLK)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .i_fill_valid(i_fill_valid), .d_fill_valid(d_fill_valid),
    .fill_data(fill_data), .fill_idx(fill_idx),
    .i_done(i_done), .d_done(d_done),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid)
  );

  function automatic logic [15:0] dfun(input logic [15:0] a);
    return a ^ 16'hC35A;
  endfunction

  // Memory model: a read issued in cycle C returns in cycle C+MEM_LAT; it ignores rst.
  always @(posedge clk) begin
    p_v    <= {p_v[MEM_LAT-2:0], mem_en & ~mem_wr};
    p_a[0] <= mem_addr;
    for (int i = 1; i < MEM_LAT; i++) p_a[i] <= p_a[i-1];
  end
  assign mem_data_valid = p_v[MEM_LAT-1];
  assign mem_data_out   = dfun(p_a[MEM_LAT-1]);

  task automatic push_fill(input logic own_d, input logic [15:0] a, input int n);
    for (int i = 0; i < n; i++) begin
      sb_t e;
      logic [2:0] ib;
      ib     = 3'(i);
      e.own_d = own_d;
      e.idx   = ib;
      e.data  = dfun({a[15:4], ib, 1'b0});
      sb.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (i_fill_valid || d_fill_valid) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL fill_unexpected: got i=%0b d=%0b idx=%0d data=%h, required no fill word", i_fill_valid, d_fill_valid, fill_idx, fill_data);
      end else begin
        sb_t e;
        e = sb.pop_front();
        if ({i_fill_valid, d_fill_valid, fill_idx, fill_data} !== {~e.own_d, e.own_d, e.idx, e.data}) begin
          n_bad++;
          $display("FAIL fill_word: got i=%0b d=%0b idx=%0d data=%h, required i=%0b d=%0b idx=%0d data=%h",
                   i_fill_valid, d_fill_valid, fill_idx, fill_data, ~e.own_d, e.own_d, e.idx, e.data);
        end
      end
    end
  end

  task automatic pulse_reset();
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (MEM_LAT + 2) @(negedge clk);
    sb.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({mem_en, mem_wr, i_fill_valid, d_fill_valid, i_done, d_done} !== 6'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b, required 000000", {mem_en, mem_wr, i_fill_valid, d_fill_valid, i_done, d_done});
    end
    n_cmp++;
    if ({mem_addr, mem_data_in, fill_idx} !== 35'b0) begin
      n_bad++; $display("FAIL reset_data: got addr=%h wdata=%h idx=%0d, required 0", mem_addr, mem_data_in, fill_idx);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (mem_en !== 1'b0) begin n_bad++; $display("FAIL idle_no_req: got mem_en=%b, required 0", mem_en); end
  endtask

  task automatic test_i_fill();
    i_addr = 16'h1236; i_req = 1'b1;
    push_fill(1'b0, 16'h1236, BLK);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      n_cmp++;
      if (mem_en !== (k <= 8)) begin n_bad++; $display("FAIL ifill_en k=%0d: got %b, required %b", k, mem_en, k <= 8); end
      if (k <= 8) begin
        n_cmp++;
        if ({mem_wr, mem_addr} !== {1'b0, 16'(16'h1230 + 2 * (k - 1))}) begin
          n_bad++; $display("FAIL ifill_addr k=%0d: got wr=%b addr=%h, required wr=0 addr=%h", k, mem_wr, mem_addr, 16'(16'h1230 + 2 * (k - 1)));
        end
      end
      n_cmp++;
      if ({i_fill_valid, i_done, d_done} !== {k >= 5 && k <= 12, k == 12, 1'b0}) begin
        n_bad++; $display("FAIL ifill_timing k=%0d: got valid=%b i_done=%b d_done=%b, required %b %b 0", k, i_fill_valid, i_done, d_done, k >= 5 && k <= 12, k == 12);
      end
      if (k == 12) i_req = 1'b0;
    end
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL ifill_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_d_write();
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0040; d_wdata = 16'hBEEF;
    @(negedge clk);
    n_cmp++;
    if ({mem_en, mem_wr, mem_addr, mem_data_in, d_done} !== {2'b11, 16'h0040, 16'hBEEF, 1'b1}) begin
      n_bad++; $display("FAIL dwrite: got en=%b wr=%b addr=%h data=%h done=%b, required 1 1 0040 beef 1", mem_en, mem_wr, mem_addr, mem_data_in, d_done);
    end
    d_req = 1'b0; d_wr = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({mem_en, d_done} !== 2'b00) begin n_bad++; $display("FAIL dwrite_done_state: got en=%b done=%b, required 0 0", mem_en, d_done); end
    i_addr = 16'h0700; i_req = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (mem_en !== 1'b0) begin n_bad++; $display("FAIL dwrite_idle_t3: got mem_en=%b, required 0", mem_en); end
    @(negedge clk);
    n_cmp++;
    if ({mem_en, mem_addr} !== {1'b1, 16'h0700}) begin
      n_bad++; $display("FAIL dwrite_next_grant: got en=%b addr=%h, required 1 0700", mem_en, mem_addr);
    end
    pulse_reset();
  endtask

  task automatic test_contention();
    pulse_reset();
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h2000; i_req = 1'b1; i_addr = 16'h3456;
    push_fill(1'b1, 16'h2000, BLK);
    push_fill(1'b0, 16'h3456, BLK);
    for (int k = 1; k <= 30; k++) begin
      logic        en_x;
      logic [15:0] a_x;
      @(negedge clk);
      en_x = (k <= 8) || (k >= 15 && k <= 22);
      a_x  = (k <= 8) ? 16'(16'h2000 + 2 * (k - 1)) : 16'(16'h3450 + 2 * (k - 15));
      n_cmp++;
      if (mem_en !== en_x || (en_x && mem_addr !== a_x)) begin
        n_bad++; $display("FAIL cont_issue k=%0d: got en=%b addr=%h, required en=%b addr=%h", k, mem_en, mem_addr, en_x, a_x);
      end
      n_cmp++;
      if ({d_done, i_done} !== {k == 12, k == 26} || (k <= 14 && i_fill_valid !== 1'b0)) begin
        n_bad++; $display("FAIL cont_done k=%0d: got d_done=%b i_done=%b ivalid=%b, required %b %b", k, d_done, i_done, i_fill_valid, k == 12, k == 26);
      end
      if (k == 12) d_req = 1'b0;
      if (k == 26) i_req = 1'b0;
    end
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL cont_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_held_req();
    int ndone = 0;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0100;
    push_fill(1'b1, 16'h0100, BLK);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (d_done) ndone++;
      n_cmp++;
      if (mem_en !== (k <= 8)) begin n_bad++; $display("FAIL held_en k=%0d: got %b, required %b", k, mem_en, k <= 8); end
      if (k == 14) d_req = 1'b0;
    end
    n_cmp++;
    if (ndone != 1 || sb.size() != 0) begin
      n_bad++; $display("FAIL held_once: got %0d done pulses, %0d pending, required 1, 0", ndone, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    i_addr = 16'h0500; i_req = 1'b1;
    push_fill(1'b0, 16'h0500, 2);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      n_cmp++;
      if (mem_en !== 1'b1) begin n_bad++; $display("FAIL rmid_en k=%0d: got %b, required 1", k, mem_en); end
    end
    rst = 1'b1; i_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({mem_en, mem_wr, i_fill_valid, d_fill_valid, i_done, d_done, mem_addr, mem_data_in, fill_idx} !== 41'b0) begin
      n_bad++; $display("FAIL rmid_outputs: got en=%b valid=%b done=%b addr=%h idx=%0d, required all 0", mem_en, i_fill_valid, i_done, mem_addr, fill_idx);
    end
    rst = 1'b0;
    for (int k = 8; k <= 14; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({mem_en, i_fill_valid, d_fill_valid, i_done, d_done} !== 5'b0) begin
        n_bad++; $display("FAIL rmid_stray k=%0d: got en=%b iv=%b dv=%b idone=%b ddone=%b, required 0", k, mem_en, i_fill_valid, d_fill_valid, i_done, d_done);
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL rmid_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    logic exp_d [3];
    logic got_d [3];
    int   svc = 0, dcnt = 0, icnt = 0;
    logic prev_en = 1'b0, fin = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    exp_d = '{1'b1, 1'b0, 1'b1};
`else
    exp_d = '{1'b1, 1'b1, 1'b0};
`endif
    pulse_reset();
    for (int s = 0; s < 3; s++) push_fill(exp_d[s], exp_d[s] ? 16'h2000 : 16'h3000, BLK);
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h2000; i_req = 1'b1; i_addr = 16'h3000;
    for (int k = 1; k <= 70 && !fin; k++) begin
      @(negedge clk);
      if (mem_en && !prev_en) begin
        if (svc < 3) got_d[svc] = (mem_addr[15:12] == 4'h2);
        svc++;
      end
      prev_en = mem_en;
      if (d_done) begin dcnt++; if (dcnt == 2) d_req = 1'b0; end
      if (i_done) begin icnt++; i_req = 1'b0; end
      if (dcnt == 2 && icnt == 1) fin = 1'b1;
    end
    d_req = 1'b0; i_req = 1'b0;
    n_cmp++;
    if (!fin || svc != 3) begin n_bad++; $display("FAIL b2b_progress: got services=%0d d=%0d i=%0d, required 3 2 1", svc, dcnt, icnt); end
    for (int s = 0; s < 3 && s < svc; s++) begin
      n_cmp++;
      if (got_d[s] !== exp_d[s]) begin n_bad++; $display("FAIL b2b_order%0d: got d_owner=%b, required %b", s, got_d[s], exp_d[s]); end
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL b2b_drain: got %0d pending, required 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_i_fill();
    test_d_write();
    test_contention();
    test_held_req();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
